// File: rtl/chord_player_pkg.sv
// rtl/chord_player_pkg.sv - shared chord encoding, widths and metadata fields
package chord_player_pkg;

  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  localparam int META_STACCATO = 0;
  localparam int META_DYN_LSB  = 1;
  localparam int META_DYN_MSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } chord_state_e;

endpackage

// File: rtl/chord_player_note_timer.sv
// rtl/chord_player_note_timer.sv - beat countdown for the current chord
module chord_player_note_timer #(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  input  logic             tick,
  output logic [DUR_W-1:0] remaining,
  output logic             expire
);

  logic [DUR_W-1:0] remaining_q, remaining_d;

  // Saturating at zero keeps a stray tick from wrapping to the maximum count.
  always_comb begin
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = duration;
    end else if (tick && (remaining_q != '0)) begin
      remaining_d = remaining_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining = remaining_q;
  assign expire    = tick && (remaining_q == DUR_W'(1));

endmodule

// File: rtl/chord_player.sv
// rtl/chord_player.sv - latches a chord, gates voices for its duration, pulses note_done
module chord_player #(
  parameter int NUM_VOICES = chord_player_pkg::NUM_VOICES,
  parameter int NOTE_W     = chord_player_pkg::NOTE_W,
  parameter int DUR_W      = chord_player_pkg::DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         beat,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note1,
  input  logic [NOTE_W-1:0]            note2,
  input  logic [NOTE_W-1:0]            note3,
  input  logic [NOTE_W-1:0]            note4,
  input  logic [1:0]                   num_notes,
  input  logic [DUR_W-1:0]             duration,
  input  logic [2:0]                   metadata,
  output logic                         note_done,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_en,
  output logic                         voice_load,
  output logic [1:0]                   dynamics,
  output logic                         busy
);
  import chord_player_pkg::*;

  chord_state_e                  state_q, state_d;
  logic [NUM_VOICES*NOTE_W-1:0]  voice_note_q, voice_note_d;
  logic [1:0]                    num_notes_q, num_notes_d;
  logic [DUR_W-1:0]              duration_q, duration_d;
  logic                          staccato_q, staccato_d;
  logic [1:0]                    dynamics_q, dynamics_d;
  logic                          voice_load_q, voice_load_d;

  logic [NOTE_W-1:0] notes_in [NUM_VOICES];
  logic              capture;
  logic              tick;
  logic              expire;
  logic              cut;
  logic [DUR_W-1:0]  remaining;

  assign notes_in = '{note1, note2, note3, note4};
  assign tick     = beat && play && (state_q == ST_PLAY);

  chord_player_note_timer #(
    .DUR_W (DUR_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .duration  (duration),
    .tick      (tick),
    .remaining (remaining),
    .expire    (expire)
  );

  // DONE accepts a new chord directly so back-to-back chords leave no idle gap.
  always_comb begin
    state_d      = state_q;
    voice_note_d = voice_note_q;
    num_notes_d  = num_notes_q;
    duration_d   = duration_q;
    staccato_d   = staccato_q;
    dynamics_d   = dynamics_q;
    voice_load_d = 1'b0;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: capture = new_note;
      ST_PLAY: if (expire) state_d = ST_DONE;
      ST_DONE: begin
        capture = new_note;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_note_d[i*NOTE_W +: NOTE_W] = (i <= int'(num_notes)) ? notes_in[i] : REST_NOTE;
      end
      num_notes_d  = num_notes;
      duration_d   = duration;
      staccato_d   = metadata[META_STACCATO];
      dynamics_d   = metadata[META_DYN_MSB:META_DYN_LSB];
      voice_load_d = 1'b1;
      state_d      = (duration == '0) ? ST_DONE : ST_PLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      voice_note_q <= '0;
      num_notes_q  <= '0;
      duration_q   <= '0;
      staccato_q   <= 1'b0;
      dynamics_q   <= '0;
      voice_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      voice_note_q <= voice_note_d;
      num_notes_q  <= num_notes_d;
      duration_q   <= duration_d;
      staccato_q   <= staccato_d;
      dynamics_q   <= dynamics_d;
      voice_load_q <= voice_load_d;
    end
  end

  // Staccato mutes the second half of the chord (floor of duration/2 beats).
  assign cut = staccato_q && (remaining <= (duration_q >> 1));

  always_comb begin
    voice_en = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_en[i] = play && (state_q == ST_PLAY) && (i <= int'(num_notes_q)) &&
                    (voice_note_q[i*NOTE_W +: NOTE_W] != REST_NOTE) && !cut;
    end
  end

  assign voice_note = voice_note_q;
  assign voice_load = voice_load_q;
  assign dynamics   = dynamics_q;
  assign note_done  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

endmodule
